// File: rtl/mac_tx_arbiter_if.sv
// Request/response bus between the TX frame sources, the arbiter and the line encoder.
interface mac_tx_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_W      = $clog2(N_SRC)
);
  logic [N_SRC-1:0]            i_req_valid;
  logic [N_SRC*DATA_WIDTH-1:0] i_req_data;
  logic [N_SRC-1:0]            i_req_last;
  logic [N_SRC-1:0]            o_req_ready;
  logic [DATA_WIDTH-1:0]       o_tx_data;
  logic                        o_tx_valid;
  logic                        o_tx_last;
  logic [SRC_W-1:0]            o_tx_src;
  logic                        i_tx_ready;

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_data, o_tx_valid, o_tx_last, o_tx_src
  );
  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_data, o_tx_valid, o_tx_last, o_tx_src
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Frame-level round-robin arbiter for the 64-bit MAC TX datapath with
// inter-frame gap insertion and runaway-frame truncation.
module mac_tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IPG_CYCLES = 2,
  parameter int MAX_BEATS  = 191,
  parameter int SRC_W      = $clog2(N_SRC)
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  mac_tx_arbiter_if.slave      bus,
  output logic                 o_busy,
  output logic                 o_overrun_err,
  output logic [15:0]          o_frame_cnt
);
  localparam int BEAT_W   = $clog2(MAX_BEATS + 1);
  localparam int GAP_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam int GAP_LAST = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;

  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic [SRC_W:0]        scan_sum;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic [SRC_W-1:0]      rr_after;
  logic [N_SRC-1:0]      ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid, tx_last, trunc;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (scan_sum >= (SRC_W+1)'(N_SRC)) scan_sum = scan_sum - (SRC_W+1)'(N_SRC);
      if (!win_found && bus.i_req_valid[scan_sum[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == SRC_W'(k)) begin
        g_valid = bus.i_req_valid[k];
        g_last  = bus.i_req_last[k];
        g_data  = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rr_after = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = 1'b0;
    ready       = '0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    trunc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = win_idx;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // A last beat landing on the cap is a normal end, not a truncation.
        trunc    = (beat_cnt_q == BEAT_LAST) && !g_last;
        tx_data  = g_data;
        tx_valid = g_valid;
        tx_last  = g_last | trunc;
        for (int k = 0; k < N_SRC; k++)
          ready[k] = (grant_q == SRC_W'(k)) & bus.i_tx_ready;
        if (g_valid && bus.i_tx_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (g_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            beat_cnt_d  = '0;
            rr_ptr_d    = rr_after;
            state_d     = (IPG_CYCLES == 0) ? IDLE : GAP;
          end else if (trunc) begin
            beat_cnt_d = '0;
            overrun_d  = 1'b1;
            rr_ptr_d   = rr_after;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the rest of the runaway frame until its own last beat.
        for (int k = 0; k < N_SRC; k++)
          ready[k] = (grant_q == SRC_W'(k));
        if (g_valid && g_last) state_d = (IPG_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_valid  = tx_valid;
  assign bus.o_tx_last   = tx_last;
  assign bus.o_tx_src    = grant_q;
  assign o_busy          = (state_q != IDLE);
  assign o_overrun_err   = overrun_q;
  assign o_frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: directed corner sequences, an arbitration vector
// table and a randomized run against a frame-level round-robin model.
module tb_mac_tx_arbiter;
  localparam int N = 4, DW = 64, IPG = 2, MAXB = 191;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  mac_tx_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus ();
  mac_tx_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW)) bus0 ();
  logic busy, ovr, busy0, ovr0;
  logic [15:0] fcnt, fcnt0;

  mac_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .IPG_CYCLES(IPG), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus.slave),
    .o_busy(busy), .o_overrun_err(ovr), .o_frame_cnt(fcnt));

  mac_tx_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .IPG_CYCLES(0), .MAX_BEATS(MAXB)) dut0 (
    .clk(clk), .i_rst_n(rst_n), .bus(bus0.slave),
    .o_busy(busy0), .o_overrun_err(ovr0), .o_frame_cnt(fcnt0));

  typedef struct { logic [3:0] mask; int exp_src; } arb_vec_t;
  typedef struct { int src; logic [63:0] data; bit last; } beat_t;

  function automatic logic [63:0] mk(input int k, input int f, input int b);
    return {8'(k), 8'(f), 16'(b), 32'hC0DE_0000 ^ 32'(k*977 + f*131 + b)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int k, input bit v, input logic [63:0] d, input bit l);
    bus.i_req_valid[k] = v;
    bus.i_req_data[k*DW +: DW] = d;
    bus.i_req_last[k] = l;
  endtask

  task automatic drive0(input int k, input bit v, input logic [63:0] d, input bit l);
    bus0.i_req_valid[k] = v;
    bus0.i_req_data[k*DW +: DW] = d;
    bus0.i_req_last[k] = l;
  endtask

  task automatic clr();
    bus.i_req_valid = '0; bus.i_req_last = '0; bus.i_req_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one frame from src and checks every forwarded beat.
  task automatic send_frame(input int src, input int nb, input bit tog, output int first_cyc);
    int b, guard, start;
    bit hs;
    b = 0; guard = 0; first_cyc = -1; start = cyc;
    drive(src, 1, mk(src, 0, 0), nb == 1);
    while (b < nb && guard < 1000) begin
      @(negedge clk);
      hs = bus.o_tx_valid && bus.i_tx_ready;
      if (tog && bus.o_tx_valid) chk("ready_mirror", bus.o_req_ready[src], bus.i_tx_ready);
      if (hs) begin
        if (b == 0) first_cyc = cyc - start;
        chk("beat_src", bus.o_tx_src, src);
        chk("beat_data", bus.o_tx_data, mk(src, 0, b));
        chk("beat_last", bus.o_tx_last, b == nb - 1);
        b++;
      end
      tick(); guard++;
      if (tog) bus.i_tx_ready = ~bus.i_tx_ready;
      if (b < nb) drive(src, 1, mk(src, 0, b), b == nb - 1);
      else drive(src, 0, '0, 0);
    end
    chk("frame_beats", b, nb);
  endtask

  arb_vec_t tbl[8];
  int fc, n, guard, a_last, b_first;
  int n_acc, n_fwd, last_at, last_cyc, ovr_n, ovr_cyc, bad_rdy;
  bit acc1;

  // randomized run state
  int nfr[N];
  int flen[N][8];
  int cf[N], cb[N], left[N], fi[N];
  bit accv[N];
  beat_t expq[$];
  beat_t e;
  int rr, total, last_end, k, ovr_bad;
  bit mid, found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // rr_ptr is 1 when the table starts (source 0 sent the previous frame).
    tbl[0] = '{4'b1111, 1}; tbl[1] = '{4'b1001, 3};
    tbl[2] = '{4'b0110, 1}; tbl[3] = '{4'b0011, 0};
    tbl[4] = '{4'b1000, 3}; tbl[5] = '{4'b0100, 2};
    tbl[6] = '{4'b0001, 0}; tbl[7] = '{4'b1110, 1};

    clr(); bus.i_tx_ready = 1'b0;
    bus0.i_req_valid = '0; bus0.i_req_last = '0; bus0.i_req_data = '0; bus0.i_tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.o_tx_valid, 0);
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_cnt", fcnt, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_data", bus.o_tx_data, 0);
    chk("rst_src", bus.o_tx_src, 0);
    rst_n = 1'b1;
    tick();

    // Zero-gap instance: two back-to-back 2-beat frames from source 0.
    bus0.i_tx_ready = 1'b1;
    n = 0; guard = 0; a_last = -1; b_first = -1;
    drive0(0, 1, mk(0, 5, 0), 0);
    while (n < 4 && guard < 40) begin
      @(negedge clk);
      if (bus0.o_tx_valid) begin
        chk("ipg0_src", bus0.o_tx_src, 0);
        chk("ipg0_data", bus0.o_tx_data, mk(0, 5, n));
        if (n == 1) a_last = cyc;
        if (n == 2) b_first = cyc;
        n++;
      end
      tick(); guard++;
      if (n < 4) drive0(0, 1, mk(0, 5, n), n[0]);
      else drive0(0, 0, '0, 0);
    end
    chk("ipg0_spacing", b_first - a_last, 2);
    chk("ipg0_cnt", fcnt0, 2);

    // Single 9-beat frame from source 0.
    bus.i_tx_ready = 1'b1;
    send_frame(0, 9, 0, fc);
    chk("t1_latency", fc, 1);
    @(negedge clk); chk("t1_gap0_busy", busy, 1); chk("t1_gap0_vld", bus.o_tx_valid, 0);
    chk("t1_gap0_rdy", bus.o_req_ready, 0);
    @(negedge clk); chk("t1_gap1_busy", busy, 1);
    @(negedge clk); chk("t1_idle", busy, 0); chk("t1_cnt", fcnt, 1);
    tick();

    // Arbitration vectors: one-beat frames offered with each mask.
    foreach (tbl[i]) begin
      for (int s = 0; s < N; s++) drive(s, tbl[i].mask[s], mk(s, 1, 0), 1);
      @(negedge clk);
      chk("arb_idle_vld", bus.o_tx_valid, 0);
      @(negedge clk);
      chk("arb_src", bus.o_tx_src, tbl[i].exp_src);
      chk("arb_vld", bus.o_tx_valid, 1);
      chk("arb_rdy", bus.o_req_ready, 4'b0001 << tbl[i].exp_src);
      chk("arb_data", bus.o_tx_data, mk(tbl[i].exp_src, 1, 0));
      tick(); clr();
      repeat (3) tick();
    end
    chk("arb_cnt", fcnt, 9);

    // Source 2, ready toggling every cycle.
    send_frame(2, 5, 1, fc);
    bus.i_tx_ready = 1'b1;
    repeat (4) tick();
    chk("t3_cnt", fcnt, 10);

    // Source 1 runs away for 200 beats while source 2 waits.
    drive(2, 1, mk(2, 2, 0), 1);
    drive(1, 1, mk(1, 3, 0), 0);
    n_acc = 0; n_fwd = 0; last_at = -1; last_cyc = -1; ovr_n = 0; ovr_cyc = -1; bad_rdy = 0; guard = 0;
    while (n_acc < 200 && guard < 1000) begin
      @(negedge clk);
      if (ovr) begin ovr_n++; ovr_cyc = cyc; end
      if (bus.o_req_ready[2]) bad_rdy++;
      acc1 = bus.i_req_valid[1] & bus.o_req_ready[1];
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        n_fwd++;
        if (bus.o_tx_last) begin last_at = n_fwd; last_cyc = cyc; end
      end
      if (acc1) n_acc++;
      tick(); guard++;
      if (n_acc < 200) drive(1, 1, mk(1, 3, n_acc), n_acc == 199);
      else drive(1, 0, '0, 0);
    end
    chk("trunc_accepted", n_acc, 200);
    chk("trunc_forwarded", n_fwd, 191);
    chk("trunc_last_at", last_at, 191);
    chk("trunc_ovr_pulses", ovr_n, 1);
    chk("trunc_ovr_timing", ovr_cyc - last_cyc, 1);
    chk("trunc_no_rdy2", bad_rdy, 0);
    chk("trunc_cnt", fcnt, 10);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_tx_valid && n < 20);
    chk("post_trunc_vld", bus.o_tx_valid, 1);
    chk("post_trunc_src", bus.o_tx_src, 2);
    tick(); clr();
    repeat (4) tick();
    chk("post_trunc_cnt", fcnt, 11);

    // Reset in the middle of beat 4 of a source-3 frame.
    drive(3, 1, mk(3, 4, 0), 0);
    n = 0; guard = 0;
    while (n < 3 && guard < 50) begin
      @(negedge clk);
      if (bus.o_tx_valid && bus.i_tx_ready) n++;
      tick(); guard++;
      drive(3, 1, mk(3, 4, n), 0);
    end
    @(negedge clk);
    chk("prerst_vld", bus.o_tx_valid, 1);
    chk("prerst_data", bus.o_tx_data, mk(3, 4, 3));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", bus.o_tx_valid, 0);
    chk("midrst_rdy", bus.o_req_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", fcnt, 0);
    clr();
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int s = 0; s < N; s++) drive(s, 1, mk(s, 6, 0), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_tx_valid && n < 20);
    chk("postrst_src", bus.o_tx_src, 0);
    chk("postrst_vld", bus.o_tx_valid, 1);
    tick(); clr();

    // Randomized run against the frame-level round-robin model.
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total = 0;
    for (int s = 0; s < N; s++) begin
      nfr[s] = $urandom_range(2, 5);
      for (int f = 0; f < nfr[s]; f++) flen[s][f] = $urandom_range(1, 6);
      cf[s] = 0; cb[s] = 0; left[s] = nfr[s]; fi[s] = 0;
      total += nfr[s];
    end
    rr = 0;
    for (int t = 0; t < total; t++) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        k = (rr + i) % N;
        if (!found && left[k] > 0) begin
          found = 1;
          for (int b = 0; b < flen[k][fi[k]]; b++)
            expq.push_back('{k, mk(k, fi[k] + 16, b), b == flen[k][fi[k]] - 1});
          left[k]--; fi[k]++;
          rr = (k + 1) % N;
        end
      end
    end
    last_end = -1; mid = 0; ovr_bad = 0; guard = 0;
    while (expq.size() > 0 && guard < 5000) begin
      for (int s = 0; s < N; s++) begin
        if (cf[s] < nfr[s])
          drive(s, (cb[s] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0),
                mk(s, cf[s] + 16, cb[s]), cb[s] == flen[s][cf[s]] - 1);
        else
          drive(s, 0, '0, 0);
      end
      bus.i_tx_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (ovr) ovr_bad++;
      for (int s = 0; s < N; s++) accv[s] = bus.i_req_valid[s] & bus.o_req_ready[s];
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        e = expq.pop_front();
        chk("rnd_src", bus.o_tx_src, e.src);
        chk("rnd_data", bus.o_tx_data, e.data);
        chk("rnd_last", bus.o_tx_last, e.last);
        if (!mid && last_end >= 0) chk("rnd_gap_ok", (cyc - last_end) >= IPG + 2, 1);
        mid = !bus.o_tx_last;
        if (bus.o_tx_last) last_end = cyc;
      end
      tick(); guard++;
      for (int s = 0; s < N; s++) begin
        if (accv[s]) begin
          cb[s]++;
          if (cb[s] == flen[s][cf[s]]) begin cb[s] = 0; cf[s]++; end
        end
      end
    end
    clr();
    chk("rnd_remaining", expq.size(), 0);
    chk("rnd_cnt", fcnt, total);
    chk("rnd_no_ovr", ovr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Frame-level round-robin arbiter that shares one 64-bit MAC TX datapath among N frame sources (generators, replay buffers, pause injector).
- Grants whole frames only and forwards the winner's beats to the downstream line encoder / mac_checker path.
- Enforces a minimum inter-frame idle gap and truncates runaway frames.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 64, beat width in bits.
- IPG_CYCLES, 2, idle cycles inserted after every frame (0 allowed).
- MAX_BEATS, 191, maximum beats per frame. 1518 bytes + 8 preamble/SFD, rounded up to 8-byte beats.
- SRC_W, $clog2(N_SRC), width of the source index.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  N_SRC  per-source beat valid
- i_req_data  in  N_SRC*DATA_WIDTH  per-source beat data; source k occupies [k*DATA_WIDTH +: DATA_WIDTH]
- i_req_last  in  N_SRC  per-source last beat of frame
- o_req_ready  out  N_SRC  per-source beat accepted
- o_tx_data  out  DATA_WIDTH  forwarded beat
- o_tx_valid  out  1  forwarded beat valid
- o_tx_last  out  1  forwarded last beat
- o_tx_src  out  SRC_W  index of the granted source; meaningful while o_tx_valid=1
- i_tx_ready  in  1  downstream accepts beat
- o_busy  out  1  high in any state other than IDLE
- o_overrun_err  out  1  one-cycle pulse when a frame is truncated
- o_frame_cnt  out  16  completed (non-truncated) frames; wraps 65535->0

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, gap_cnt=0, o_frame_cnt=0. All outputs 0 immediately, including o_req_ready and o_tx_valid.
- A reset mid-frame aborts the frame with no last beat emitted. Sources must restart their frames.
- Handshake: a beat transfers when o_tx_valid & i_tx_ready. o_req_ready[g] = i_tx_ready in XFER only. All non-granted ready bits are 0.
- Datapath: combinational passthrough of the granted source. o_tx_data = i_req_data[g], o_tx_valid = i_req_valid[g], o_tx_last = i_req_last[g] | trunc (see XFER). Zero added latency.
- Arbitration:
  - Search starts at rr_ptr, scanning rr_ptr, rr_ptr+1, ... mod N_SRC. The first source with i_req_valid=1 wins.
  - After any frame ends (normal or truncated), rr_ptr = (g+1) mod N_SRC.
- FSM states:
  - IDLE: o_busy=0. If any i_req_valid, register winner g and go to XFER. Grant-to-first-beat latency is 1 cycle. No ready is asserted in IDLE.
  - XFER:
    - beat_cnt increments on each handshake.
    - Handshake with i_req_last[g]=1: o_frame_cnt++, beat_cnt=0, go to GAP (or to IDLE if IPG_CYCLES=0).
    - Handshake where beat_cnt==MAX_BEATS-1 and i_req_last[g]=0: trunc=1 for that beat, so o_tx_last=1. o_overrun_err pulses the next cycle. Go to DRAIN. o_frame_cnt is not incremented.
    - The source deasserting valid mid-frame stalls; the grant is held.
  - DRAIN: o_tx_valid=0, o_req_ready[g]=1. Beats from g are discarded. On a discarded beat with i_req_last[g]=1, go to GAP/IDLE.
  - GAP: all ready=0, o_tx_valid=0. Stay exactly IPG_CYCLES cycles (gap_cnt counts 0..IPG_CYCLES-1), then go to IDLE.
- Simultaneous events:
  - Last and truncation on the same beat: treated as a normal end. Counted, no error.
  - A source raising valid during GAP waits; it is arbitrated in the IDLE cycle that follows.
- A one-beat frame (valid & last on the first beat) is legal.
- Back-to-back minimum spacing from one source: last beat, IPG_CYCLES gap cycles, 1 IDLE cycle, next first beat.

Test Plan:
- Single source 0 sends a 9-beat frame, i_tx_ready=1 → grant one cycle after valid; 9 beats with o_tx_src=0; o_tx_last on beat 9; o_frame_cnt=1; then 2 GAP cycles, then IDLE.
- Sources 0,1,3 all valid continuously, each sending 3-beat frames → grant order 0,1,3,0,1,3; no beat interleaving; every frame separated by ≥3 non-valid cycles.
- i_tx_ready toggled 1/0 every cycle during a 5-beat frame from source 2 → exactly 5 handshakes; o_req_ready[2] mirrors i_tx_ready; data order preserved.
- Source 1 streams 200 beats without last, MAX_BEATS=191 → beat 191 output with o_tx_last=1; o_overrun_err pulses once; beats 192..200 are accepted but not forwarded; o_frame_cnt unchanged; next grant goes to source 2 if it is valid.
- Reset asserted on beat 4 of a frame → o_tx_valid and all ready bits go 0 without waiting for a clock edge. After release, o_frame_cnt=0, rr_ptr=0, and source 0 wins when all sources are valid.
- IPG_CYCLES=0 with source 0 back-to-back → next frame's first beat appears 2 cycles after the previous last beat (one IDLE cycle plus the grant cycle).
